// File: rtl/gas_alarm_controller_pkg.sv
// Shared definitions for the gas detector chain: state encoding and level width.
// Latency: none, declarations only.
// Backpressure: not applicable.
package gas_alarm_controller_pkg;

    localparam int GAS_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WARN    = 2'b01,
        ST_ALARM   = 2'b10,
        ST_LATCHED = 2'b11
    } state_t;

endpackage

// File: rtl/gas_alarm_controller_debounce.sv
// Saturating consecutive-edge counter; hit flags the edge that completes THRESH qualifying edges.
// Latency: hit is combinational from cond and the registered count.
// Backpressure: none, it samples every edge.
module gas_debounce_counter #(
    parameter int THRESH = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic cond,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(THRESH + 1);
    localparam logic [CW-1:0] LAST = CW'(THRESH - 1);
    localparam logic [CW-1:0] MAX  = CW'(THRESH);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (clr || !cond) begin
            cnt <= '0;
        end else if (cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Saturated count still reports hit so a held condition keeps qualifying.
    assign hit = cond && (cnt >= LAST);

endmodule

// File: rtl/gas_alarm_controller.sv
// Debounced gas escalation FSM driving fan, shut-off valve and pulsed siren.
// Latency: outputs registered on the same edge as the state change.
// Backpressure: none, inputs are sampled every edge.
module gas_alarm_controller
    import gas_alarm_controller_pkg::*;
#(
    parameter int WARN_LVL   = 2,
    parameter int ALARM_LVL  = 5,
    parameter int HOLD_CYC   = 4,
    parameter int CLEAR_CYC  = 8,
    parameter int BLINK_HALF = 3
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [GAS_W-1:0] gas_level,
    input  logic             ack,
    output logic             fan_on,
    output logic             valve_close,
    output logic             siren,
    output logic [1:0]       state_o
);

    localparam logic [GAS_W-1:0] WARN_TH  = GAS_W'(WARN_LVL);
    localparam logic [GAS_W-1:0] ALARM_TH = GAS_W'(ALARM_LVL);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        state;
    state_t        nxt;
    logic          hi, wq, lo;
    logic          alarm_hit, warn_hit, clear_hit;
    logic          clr;
    logic          mute;
    logic          phase;
    logic [BW-1:0] blink;
    logic          blink_wrap;
    logic          phase_nxt;
    logic          mute_nxt;

    assign hi = gas_level >= ALARM_TH;
    assign wq = gas_level >= WARN_TH;
    assign lo = !wq;

    // Any state change restarts all three debounce runs.
    assign clr = (nxt != state);

    gas_debounce_counter #(.THRESH(HOLD_CYC)) u_alarm_cnt (
        .clk  (clk),
        .arst (arst),
        .cond (hi),
        .clr  (clr),
        .hit  (alarm_hit)
    );

    gas_debounce_counter #(.THRESH(HOLD_CYC)) u_warn_cnt (
        .clk  (clk),
        .arst (arst),
        .cond (wq),
        .clr  (clr),
        .hit  (warn_hit)
    );

    gas_debounce_counter #(.THRESH(CLEAR_CYC)) u_clear_cnt (
        .clk  (clk),
        .arst (arst),
        .cond (lo),
        .clr  (clr),
        .hit  (clear_hit)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (alarm_hit)     nxt = ST_ALARM;
                else if (warn_hit) nxt = ST_WARN;
            end
            ST_WARN: begin
                if (alarm_hit)      nxt = ST_ALARM;
                else if (clear_hit) nxt = ST_IDLE;
            end
            ST_ALARM: begin
                if (clear_hit) nxt = ST_LATCHED;
            end
            ST_LATCHED: begin
                if (alarm_hit)      nxt = ST_ALARM;
                else if (ack && lo) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign blink_wrap = (blink == BLINK_LAST);
    assign phase_nxt  = blink_wrap ? ~phase : phase;
    assign mute_nxt   = mute | ack;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= ST_IDLE;
            fan_on      <= 1'b0;
            valve_close <= 1'b0;
            siren       <= 1'b0;
            mute        <= 1'b0;
            phase       <= 1'b0;
            blink       <= '0;
        end else begin
            state       <= nxt;
            fan_on      <= (nxt != ST_IDLE);
            valve_close <= (nxt == ST_ALARM) || (nxt == ST_LATCHED);
            if (nxt == ST_ALARM && state != ST_ALARM) begin
                // Fresh alarm: siren sounds immediately, any earlier mute is dropped.
                mute  <= 1'b0;
                phase <= 1'b1;
                blink <= '0;
                siren <= 1'b1;
            end else if (nxt == ST_ALARM) begin
                mute  <= mute_nxt;
                phase <= phase_nxt;
                blink <= blink_wrap ? '0 : blink + 1'b1;
                siren <= phase_nxt & ~mute_nxt;
            end else begin
                phase <= 1'b0;
                blink <= '0;
                siren <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Self-checking bench: directed scenarios plus randomized levels/acks against a run-length reference model.
module tb_gas_alarm_controller;

    localparam int HOLD  = 4;
    localparam int CLEAR = 8;
    localparam int BH    = 3;
    localparam int WL    = 2;
    localparam int AL    = 5;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [2:0] gas_level = 3'd0;
    logic       ack = 1'b0;
    logic       fan_on, valve_close, siren;
    logic [1:0] state_o;

    gas_alarm_controller dut (
        .clk         (clk),
        .arst        (arst),
        .gas_level   (gas_level),
        .ack         (ack),
        .fan_on      (fan_on),
        .valve_close (valve_close),
        .siren       (siren),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state as spec encoding, lengths of current qualifying runs,
    // cycles spent in the current alarm episode and the mute flag.
    int m_st, run_hi, run_wq, run_lo, m_k;
    bit m_mute;

    task automatic model_reset();
        m_st = 0; run_hi = 0; run_wq = 0; run_lo = 0; m_k = 0; m_mute = 0;
    endtask

    task automatic model_step(input int gl, input bit ak);
        bit hi, wq, lo, ahit, whit, chit;
        int nst;
        hi = (gl >= AL);
        wq = (gl >= WL);
        lo = !wq;
        ahit = hi && (run_hi + 1 >= HOLD);
        whit = wq && (run_wq + 1 >= HOLD);
        chit = lo && (run_lo + 1 >= CLEAR);
        nst = m_st;
        case (m_st)
            0: if (ahit) nst = 2; else if (whit) nst = 1;
            1: if (ahit) nst = 2; else if (chit) nst = 0;
            2: if (chit) nst = 3;
            default: if (ahit) nst = 2; else if (ak && lo) nst = 0;
        endcase
        if (nst != m_st) begin
            run_hi = 0; run_wq = 0; run_lo = 0;
        end else begin
            run_hi = hi ? run_hi + 1 : 0;
            run_wq = wq ? run_wq + 1 : 0;
            run_lo = lo ? run_lo + 1 : 0;
        end
        if (nst == 2 && m_st != 2) begin
            m_k = 0; m_mute = 0;
        end else if (nst == 2) begin
            m_k++;
            if (ak) m_mute = 1;
        end
        m_st = nst;
    endtask

    task automatic check_outputs(input string tag);
        int exp_siren;
        exp_siren = (m_st == 2 && !m_mute && ((m_k / BH) % 2 == 0)) ? 1 : 0;
        chk({tag, ".state"}, int'(state_o), m_st);
        chk({tag, ".fan"}, int'(fan_on), (m_st != 0) ? 1 : 0);
        chk({tag, ".valve"}, int'(valve_close), (m_st >= 2) ? 1 : 0);
        chk({tag, ".siren"}, int'(siren), exp_siren);
    endtask

    task automatic step(input string tag, input int gl, input bit ak);
        gas_level = 3'(gl);
        ack = ak;
        @(posedge clk);
        model_step(gl, ak);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".state"}, int'(state_o), 0);
        chk({tag, ".fan"}, int'(fan_on), 0);
        chk({tag, ".valve"}, int'(valve_close), 0);
        chk({tag, ".siren"}, int'(siren), 0);
    endtask

    // Mid-cycle asynchronous reset: outputs must drop before any clock edge.
    task automatic rst_pulse();
        arst = 1'b1;
        #1;
        check_zero("arst_async");
        @(posedge clk);
        #1;
        check_zero("arst_hold");
        #3;
        arst = 1'b0;
        model_reset();
    endtask

    int siren_pat[7] = '{1, 1, 1, 0, 0, 0, 1};

    initial begin
        int gl, len;
        bit ak;
        model_reset();

        // 1: reset held with high gas, then 4 edges to alarm
        gas_level = 3'd6;
        #2;  check_zero("t1_rst_a");
        #10; check_zero("t1_rst_b");
        #11; arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("t1_pre", 6, 0);
            chk("t1_not_yet", int'(state_o), 0);
        end
        step("t1_alarm", 6, 0);
        chk("t1_alarm_state", int'(state_o), 2);

        rst_pulse();

        // 2: warn debounce with an interrupted run
        for (int i = 0; i < 3; i++) step("t2_run1", 3, 0);
        step("t2_gap", 1, 0);
        for (int i = 0; i < 3; i++) step("t2_run2", 3, 0);
        chk("t2_still_idle", int'(state_o), 0);
        step("t2_warn", 3, 0);
        chk("t2_warn_state", int'(state_o), 1);
        chk("t2_warn_fan", int'(fan_on), 1);

        // 6: warn clear interrupted at the 8th edge by a warn-level sample
        for (int i = 0; i < 7; i++) step("t6_low1", 1, 0);
        step("t6_bump", 2, 0);
        for (int i = 0; i < 7; i++) step("t6_low2", 1, 0);
        chk("t6_still_warn", int'(state_o), 1);
        step("t6_clear", 1, 0);
        chk("t6_idle", int'(state_o), 0);

        // 3: direct alarm with siren blink pattern
        for (int i = 0; i < 3; i++) step("t3_pre", 7, 0);
        for (int i = 0; i < 7; i++) begin
            step("t3_alarm", 7, 0);
            chk("t3_state", int'(state_o), 2);
            chk("t3_siren_pat", int'(siren), siren_pat[i]);
        end
        chk("t3_valve", int'(valve_close), 1);

        // 4: mute then latch
        step("t4_ack", 7, 1);
        chk("t4_muted", int'(siren), 0);
        chk("t4_state", int'(state_o), 2);
        for (int i = 0; i < 7; i++) step("t4_low", 0, 0);
        chk("t4_not_latched", int'(state_o), 2);
        step("t4_latch", 0, 0);
        chk("t4_latched", int'(state_o), 3);
        chk("t4_latched_siren", int'(siren), 0);
        chk("t4_latched_valve", int'(valve_close), 1);

        // 5: ack ignored at warn level, honoured when low; then re-alarm from latched
        step("t5_ack_hi", 4, 1);
        chk("t5_stay", int'(state_o), 3);
        step("t5_ack_lo", 0, 1);
        chk("t5_idle", int'(state_o), 0);
        for (int i = 0; i < 4; i++) step("t5_alarm", 7, 0);
        for (int i = 0; i < 8; i++) step("t5_low", 0, 0);
        chk("t5_relatched", int'(state_o), 3);
        for (int i = 0; i < 4; i++) step("t5_realarm", 5, 1);
        chk("t5_realarm_state", int'(state_o), 2);
        chk("t5_unmuted", int'(siren), 1);
        step("t5_after", 5, 0);

        // Randomized runs of held levels with sporadic ack and async reset
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 39) == 0) rst_pulse();
            gl  = $urandom_range(0, 7);
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                ak = ($urandom_range(0, 7) == 0);
                step("rand", gl, ak);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
